// File: rtl/phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list
//   Circular FIFO of free physical-register tags sitting between ROB retire
//   (producer, up to two released tags per cycle) and rename (consumer, one
//   tag per cycle). An in_list bitmap mirrors FIFO membership so illegal
//   frees can be detected.
//
// Ports
//   clk, rstn                 clock (rising edge), async active-low reset
//   alloc_req                 rename wants a destination tag this cycle
//   alloc_valid / alloc_tag   head tag offered to rename
//   stall                     list empty, rename must hold
//   free0_valid / free0_tag   retire slot 0 release (older)
//   free1_valid / free1_tag   retire slot 1 release (younger)
//   free_count                tags currently in the list
//   err_dbl_free              sticky: a freed tag was already in the list
//   err_overflow              sticky: a push would exceed capacity
//
// Handshake: alloc_tag is a combinational peek of the FIFO head. When
// alloc_valid (= alloc_req & ~stall) is high, the pop happens at the next
// rising clk edge; rename consumes alloc_tag in that same cycle. There is no
// back-pressure on the free slots: every valid free is either accepted or
// dropped (with an error flag, unless the tag is 0).
// ---------------------------------------------------------------------------
module phys_reg_free_list #(
  parameter int NUM_PREG = 64,
  parameter int NUM_AREG = 32,
  localparam int TW = $clog2(NUM_PREG),
  localparam int CW = TW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          alloc_req,
  output logic          alloc_valid,
  output logic [TW-1:0] alloc_tag,
  output logic          stall,
  input  logic          free0_valid,
  input  logic [TW-1:0] free0_tag,
  input  logic          free1_valid,
  input  logic [TW-1:0] free1_tag,
  output logic [CW-1:0] free_count,
  output logic          err_dbl_free,
  output logic          err_overflow
);

  // Preg 0 is never in the list, so occupancy tops out one below NUM_PREG.
  localparam logic [CW-1:0] MAX_OCC   = CW'(NUM_PREG - 1);
  localparam int            RST_COUNT = NUM_PREG - NUM_AREG;

  logic [TW-1:0]       tag_mem [NUM_PREG];
  logic [TW-1:0]       head;
  logic [TW-1:0]       tail;
  logic [CW-1:0]       count;
  logic [NUM_PREG-1:0] in_list;

  logic          cand0, cand1;
  logic          new0, new1, dup1;
  logic          acc0, acc1;
  logic          dbl_hit, ovf_hit;
  logic [CW-1:0] space;
  logic [CW-1:0] need1;
  logic [1:0]    n_acc;
  logic [TW-1:0] wr1_ptr;

  assign alloc_tag   = tag_mem[head];
  assign stall       = (count == '0);
  assign alloc_valid = alloc_req & ~stall;
  assign free_count  = count;

  // Free-slot screening. Membership is judged on the pre-edge bitmap, so a
  // tag being popped this cycle still counts as "in the list".
  assign cand0 = free0_valid & (free0_tag != '0);
  assign cand1 = free1_valid & (free1_tag != '0);
  assign new0  = cand0 & ~in_list[free0_tag];
  // Same tag on both slots: the older slot wins, the younger is a double free.
  assign dup1  = cand0 & (free1_tag == free0_tag);
  assign new1  = cand1 & ~in_list[free1_tag] & ~dup1;

  // Room left after this cycle's pop; slot1 is the first to be squeezed out.
  assign space = MAX_OCC - count + {{(CW-1){1'b0}}, alloc_valid};
  assign need1 = acc0 ? CW'(2) : CW'(1);
  assign acc0  = new0 & (space >= CW'(1));
  assign acc1  = new1 & (space >= need1);

  assign dbl_hit = (cand0 & ~new0) | (cand1 & ~new1);
  assign ovf_hit = (new0 & ~acc0) | (new1 & ~acc1);

  assign n_acc   = {1'b0, acc0} + {1'b0, acc1};
  assign wr1_ptr = acc0 ? tail + TW'(1) : tail;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        tag_mem[i] <= (i < RST_COUNT) ? TW'(NUM_AREG + i) : '0;
        in_list[i] <= (i >= NUM_AREG);
      end
      head         <= '0;
      tail         <= TW'(RST_COUNT);
      count        <= CW'(RST_COUNT);
      err_dbl_free <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (alloc_valid) begin
        head               <= head + TW'(1);
        in_list[alloc_tag] <= 1'b0;
      end
      // An accepted tag is never the popped tag (it was not in the list),
      // so these bitmap writes never collide with the clear above.
      if (acc0) begin
        tag_mem[tail]      <= free0_tag;
        in_list[free0_tag] <= 1'b1;
      end
      if (acc1) begin
        tag_mem[wr1_ptr]   <= free1_tag;
        in_list[free1_tag] <= 1'b1;
      end
      tail  <= tail + {{(TW-2){1'b0}}, n_acc};
      count <= count - {{(CW-1){1'b0}}, alloc_valid} + {{(CW-2){1'b0}}, n_acc};
      if (dbl_hit) err_dbl_free <= 1'b1;
      if (ovf_hit) err_overflow <= 1'b1;
    end
  end

endmodule
